// File: rtl/riscv_bu_resolve.sv
// Execute-stage branch resolution: detects mispredicts, raises a one-cycle flush with the
// redirect PC, owns the global history register and drives predictor update pulses.
module riscv_bu_resolve #(
  parameter int unsigned      XLEN           = 32,
  parameter logic [XLEN-1:0]  PC_INIT        = 'h200,
  parameter bit               HAS_BPU        = 1'b1,
  parameter int unsigned      BP_GLOBAL_BITS = 2,
  parameter int unsigned      CNT_BITS       = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ex_stall_i,
  input  logic                      ex_valid_i,
  input  logic                      ex_is_cbranch_i,
  input  logic                      ex_is_jump_i,
  input  logic [XLEN-1:0]           ex_pc_i,
  input  logic [XLEN-1:0]           ex_pred_npc_i,
  input  logic [1:0]                ex_bp_predict_i,
  input  logic                      ex_taken_i,
  input  logic [XLEN-1:0]           ex_target_i,
  input  logic                      cnt_clr_i,
  output logic                      bu_flush_o,
  output logic [XLEN-1:0]           bu_nxt_pc_o,
  output logic                      bu_bp_update_o,
  output logic [XLEN-1:0]           bu_bp_pc_o,
  output logic [BP_GLOBAL_BITS-1:0] bu_bp_history_o,
  output logic [1:0]                bu_bp_predict_o,
  output logic                      bu_bp_btaken_o,
  output logic [CNT_BITS-1:0]       cnt_branch_o,
  output logic [CNT_BITS-1:0]       cnt_mispredict_o
);

  logic                      flush_q, flush_d;
  logic [XLEN-1:0]           nxt_pc_q, nxt_pc_d;
  // Registered "accepted conditional branch"; drives both the update pulse and the counter.
  logic                      cb_evt_q, cb_evt_d;
  logic [XLEN-1:0]           bp_pc_q, bp_pc_d;
  logic [1:0]                bp_predict_q, bp_predict_d;
  logic                      btaken_q, btaken_d;
  logic [BP_GLOBAL_BITS-1:0] ghr_q, ghr_d, ghr_shift;
  logic [CNT_BITS-1:0]       cnt_branch_q, cnt_branch_d;
  logic [CNT_BITS-1:0]       cnt_mis_q, cnt_mis_d;

  logic            accept, taken_eff, mispredict;
  logic [XLEN-1:0] anpc;

  if (BP_GLOBAL_BITS == 1) begin : g_ghr1
    assign ghr_shift = btaken_q;
  end else begin : g_ghrn
    assign ghr_shift = {ghr_q[BP_GLOBAL_BITS-2:0], btaken_q};
  end

  always_comb begin
    // The EX instruction seen during a flush cycle is wrong-path.
    accept     = ex_valid_i & ~ex_stall_i & ~flush_q;
    taken_eff  = ex_is_jump_i | (ex_is_cbranch_i & ex_taken_i);
    anpc       = taken_eff ? ex_target_i : ex_pc_i + XLEN'(4);
    mispredict = accept & (ex_is_cbranch_i | ex_is_jump_i) & (anpc != ex_pred_npc_i);

    flush_d  = mispredict;
    nxt_pc_d = mispredict ? anpc : nxt_pc_q;
    cb_evt_d = accept & ex_is_cbranch_i;

    bp_pc_d      = bp_pc_q;
    bp_predict_d = bp_predict_q;
    btaken_d     = btaken_q;
    if (HAS_BPU && cb_evt_d) begin
      bp_pc_d      = ex_pc_i;
      bp_predict_d = ex_bp_predict_i;
      btaken_d     = ex_taken_i;
    end

    ghr_d = ghr_q;
    if (HAS_BPU && cb_evt_q) begin
      ghr_d = ghr_shift;
    end

    cnt_branch_d = cnt_branch_q;
    cnt_mis_d    = cnt_mis_q;
    if (cnt_clr_i) begin
      cnt_branch_d = '0;
      cnt_mis_d    = '0;
    end else begin
      if (cb_evt_q) cnt_branch_d = cnt_branch_q + CNT_BITS'(1);
      if (flush_q)  cnt_mis_d    = cnt_mis_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_q      <= 1'b0;
      nxt_pc_q     <= PC_INIT;
      cb_evt_q     <= 1'b0;
      bp_pc_q      <= '0;
      bp_predict_q <= '0;
      btaken_q     <= 1'b0;
      ghr_q        <= '0;
      cnt_branch_q <= '0;
      cnt_mis_q    <= '0;
    end else begin
      flush_q      <= flush_d;
      nxt_pc_q     <= nxt_pc_d;
      cb_evt_q     <= cb_evt_d;
      bp_pc_q      <= bp_pc_d;
      bp_predict_q <= bp_predict_d;
      btaken_q     <= btaken_d;
      ghr_q        <= ghr_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_mis_q    <= cnt_mis_d;
    end
  end

  assign bu_flush_o       = flush_q;
  assign bu_nxt_pc_o      = nxt_pc_q;
  assign bu_bp_update_o   = HAS_BPU & cb_evt_q;
  assign bu_bp_pc_o       = bp_pc_q;
  assign bu_bp_history_o  = ghr_q;
  assign bu_bp_predict_o  = bp_predict_q;
  assign bu_bp_btaken_o   = btaken_q;
  assign cnt_branch_o     = cnt_branch_q;
  assign cnt_mispredict_o = cnt_mis_q;

endmodule

// File: tb/tb_riscv_bu_resolve.sv
// Directed bench for riscv_bu_resolve: a default instance plus a predictor-less,
// 4-bit-counter, 1-bit-history instance driven from the same stimulus.
module tb_riscv_bu_resolve;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_stall_i, ex_valid_i, ex_is_cbranch_i, ex_is_jump_i, ex_taken_i, cnt_clr_i;
  logic [31:0] ex_pc_i, ex_pred_npc_i, ex_target_i;
  logic [1:0]  ex_bp_predict_i;

  logic        flush, update, btaken;
  logic [31:0] nxt_pc, bp_pc, cnt_branch, cnt_mis;
  logic [1:0]  history, predict;

  logic        flush_b, update_b, btaken_b;
  logic [31:0] nxt_pc_b, bp_pc_b;
  logic [0:0]  history_b;
  logic [1:0]  predict_b;
  logic [3:0]  cnt_branch_b, cnt_mis_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  riscv_bu_resolve dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ex_stall_i(ex_stall_i), .ex_valid_i(ex_valid_i),
    .ex_is_cbranch_i(ex_is_cbranch_i), .ex_is_jump_i(ex_is_jump_i), .ex_pc_i(ex_pc_i),
    .ex_pred_npc_i(ex_pred_npc_i), .ex_bp_predict_i(ex_bp_predict_i), .ex_taken_i(ex_taken_i),
    .ex_target_i(ex_target_i), .cnt_clr_i(cnt_clr_i), .bu_flush_o(flush), .bu_nxt_pc_o(nxt_pc),
    .bu_bp_update_o(update), .bu_bp_pc_o(bp_pc), .bu_bp_history_o(history),
    .bu_bp_predict_o(predict), .bu_bp_btaken_o(btaken), .cnt_branch_o(cnt_branch),
    .cnt_mispredict_o(cnt_mis)
  );

  riscv_bu_resolve #(.HAS_BPU(1'b0), .BP_GLOBAL_BITS(1), .CNT_BITS(4)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .ex_stall_i(ex_stall_i), .ex_valid_i(ex_valid_i),
    .ex_is_cbranch_i(ex_is_cbranch_i), .ex_is_jump_i(ex_is_jump_i), .ex_pc_i(ex_pc_i),
    .ex_pred_npc_i(ex_pred_npc_i), .ex_bp_predict_i(ex_bp_predict_i), .ex_taken_i(ex_taken_i),
    .ex_target_i(ex_target_i), .cnt_clr_i(cnt_clr_i), .bu_flush_o(flush_b),
    .bu_nxt_pc_o(nxt_pc_b), .bu_bp_update_o(update_b), .bu_bp_pc_o(bp_pc_b),
    .bu_bp_history_o(history_b), .bu_bp_predict_o(predict_b), .bu_bp_btaken_o(btaken_b),
    .cnt_branch_o(cnt_branch_b), .cnt_mispredict_o(cnt_mis_b)
  );

  typedef struct {
    logic        cb, jmp, tk;
    logic [31:0] pc, pred, tgt;
    logic [1:0]  prd;
    logic        e_flush;
    logic [31:0] e_nxt;
    logic        e_upd;
    logic [1:0]  e_hist;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic cb, input logic jmp, input logic tk, input logic [31:0] pc,
                       input logic [31:0] pred, input logic [31:0] tgt, input logic [1:0] prd);
    ex_valid_i      = 1'b1;
    ex_is_cbranch_i = cb;
    ex_is_jump_i    = jmp;
    ex_taken_i      = tk;
    ex_pc_i         = pc;
    ex_pred_npc_i   = pred;
    ex_target_i     = tgt;
    ex_bp_predict_i = prd;
  endtask

  task automatic idle();
    ex_valid_i      = 1'b0;
    ex_is_cbranch_i = 1'b0;
    ex_is_jump_i    = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [1:0] hexp[3];
    hexp[0] = 2'b00; hexp[1] = 2'b01; hexp[2] = 2'b11;

    //           cb   jmp  tk   pc            pred          tgt           prd    fl   nxt        up   hist
    tv[0] = '{1'b1,1'b0,1'b0,32'h100,      32'h104,      32'h150,      2'b01, 1'b0,32'h200,1'b1,2'b00};
    tv[1] = '{1'b1,1'b0,1'b1,32'h200,      32'h204,      32'h180,      2'b10, 1'b1,32'h180,1'b1,2'b00};
    tv[2] = '{1'b0,1'b1,1'b0,32'h300,      32'h304,      32'h400,      2'b00, 1'b1,32'h400,1'b0,2'b01};
    tv[3] = '{1'b1,1'b0,1'b1,32'h500,      32'h600,      32'h600,      2'b11, 1'b0,32'h400,1'b1,2'b01};
    tv[4] = '{1'b0,1'b0,1'b0,32'h700,      32'h900,      32'h0,        2'b00, 1'b0,32'h400,1'b0,2'b11};
    tv[5] = '{1'b1,1'b0,1'b0,32'hFFFFFFFC, 32'h0,        32'h40,       2'b00, 1'b0,32'h400,1'b1,2'b11};
    tv[6] = '{1'b1,1'b0,1'b0,32'h800,      32'h900,      32'h900,      2'b11, 1'b1,32'h804,1'b1,2'b10};
    tv[7] = '{1'b0,1'b1,1'b0,32'h900,      32'hA00,      32'hA00,      2'b00, 1'b0,32'h804,1'b0,2'b00};

    rst_ni = 1'b0; ex_stall_i = 1'b0; cnt_clr_i = 1'b0; ex_taken_i = 1'b0;
    ex_pc_i = '0; ex_pred_npc_i = '0; ex_target_i = '0; ex_bp_predict_i = '0;
    idle();
    repeat (2) tick();
    rst_ni = 1'b1;
    repeat (5) tick();
    chk("rst_flush", {31'b0, flush}, 0);
    chk("rst_nxt_pc", nxt_pc, 32'h200);
    chk("rst_update", {31'b0, update}, 0);
    chk("rst_bp_pc", bp_pc, 0);
    chk("rst_predict", {30'b0, predict}, 0);
    chk("rst_btaken", {31'b0, btaken}, 0);
    chk("rst_history", {30'b0, history}, 0);
    chk("rst_cnt_branch", cnt_branch, 0);
    chk("rst_cnt_mis", cnt_mis, 0);

    for (int i = 0; i < 8; i++) begin
      drive(tv[i].cb, tv[i].jmp, tv[i].tk, tv[i].pc, tv[i].pred, tv[i].tgt, tv[i].prd);
      tick();
      chk($sformatf("v%0d_flush", i), {31'b0, flush}, {31'b0, tv[i].e_flush});
      chk($sformatf("v%0d_nxt_pc", i), nxt_pc, tv[i].e_nxt);
      chk($sformatf("v%0d_update", i), {31'b0, update}, {31'b0, tv[i].e_upd});
      chk($sformatf("v%0d_history", i), {30'b0, history}, {30'b0, tv[i].e_hist});
      chk($sformatf("v%0d_update_nobpu", i), {31'b0, update_b}, 0);
      if (tv[i].e_upd) begin
        chk($sformatf("v%0d_bp_pc", i), bp_pc, tv[i].pc);
        chk($sformatf("v%0d_predict", i), {30'b0, predict}, {30'b0, tv[i].prd});
        chk($sformatf("v%0d_btaken", i), {31'b0, btaken}, {31'b0, tv[i].tk});
      end
      idle();
      tick();
      chk($sformatf("v%0d_flush_drop", i), {31'b0, flush}, 0);
    end
    chk("tbl_history", {30'b0, history}, 0);
    chk("tbl_cnt_branch", cnt_branch, 5);
    chk("tbl_cnt_mis", cnt_mis, 3);
    chk("tbl_cnt_branch_nobpu", {28'b0, cnt_branch_b}, 5);
    chk("tbl_cnt_mis_nobpu", {28'b0, cnt_mis_b}, 3);
    chk("tbl_history_nobpu", {31'b0, history_b}, 0);

    // Instruction in the flush cycle is wrong-path and must not pulse.
    cnt_clr_i = 1'b1; tick(); cnt_clr_i = 1'b0;
    chk("clr_cnt_mis", cnt_mis, 0);
    drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h204, 32'h180, 2'b01);
    tick();
    chk("fb_flush", {31'b0, flush}, 1);
    chk("fb_nxt_pc", nxt_pc, 32'h180);
    chk("fb_btaken", {31'b0, btaken}, 1);
    drive(1'b1, 1'b0, 1'b0, 32'h180, 32'h184, 32'h1C0, 2'b01);
    tick();
    chk("fb_no_pulse", {31'b0, update}, 0);
    chk("fb_no_flush", {31'b0, flush}, 0);
    chk("fb_history", {30'b0, history}, 1);
    chk("fb_cnt_mis", cnt_mis, 1);
    chk("fb_cnt_branch", cnt_branch, 1);
    idle(); tick();

    // Back-to-back taken, correctly predicted branches.
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h1000 + 32'h100 * k, 32'h1040 + 32'h100 * k,
            32'h1040 + 32'h100 * k, 2'b10);
      tick();
      chk($sformatf("b2b%0d_update", k), {31'b0, update}, 1);
      chk($sformatf("b2b%0d_history", k), {30'b0, history}, {30'b0, hexp[k]});
    end
    idle(); tick();
    chk("b2b_history", {30'b0, history}, 3);
    chk("b2b_cnt_branch", cnt_branch, 3);
    chk("b2b_flush", {31'b0, flush}, 0);

    // Same with a 2-cycle stall between the first and second.
    pulse_reset();
    drive(1'b1, 1'b0, 1'b1, 32'h1000, 32'h1040, 32'h1040, 2'b10);
    tick();
    chk("st0_update", {31'b0, update}, 1);
    chk("st0_history", {30'b0, history}, 0);
    drive(1'b1, 1'b0, 1'b1, 32'h1100, 32'h1140, 32'h1140, 2'b10);
    ex_stall_i = 1'b1;
    for (int s = 0; s < 2; s++) begin
      tick();
      chk($sformatf("stall%0d_update", s), {31'b0, update}, 0);
      chk($sformatf("stall%0d_history", s), {30'b0, history}, 1);
    end
    ex_stall_i = 1'b0;
    tick();
    chk("st1_update", {31'b0, update}, 1);
    chk("st1_history", {30'b0, history}, 1);
    drive(1'b1, 1'b0, 1'b1, 32'h1200, 32'h1240, 32'h1240, 2'b10);
    tick();
    chk("st2_update", {31'b0, update}, 1);
    chk("st2_history", {30'b0, history}, 3);
    idle(); tick();
    chk("st_history", {30'b0, history}, 3);
    chk("st_cnt_branch", cnt_branch, 3);

    // 16 branches wrap the 4-bit counter.
    cnt_clr_i = 1'b1; tick(); cnt_clr_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h2000 + 32'd4 * k, 32'h2004 + 32'd4 * k, 32'h3000, 2'b00);
      tick();
    end
    idle(); tick();
    chk("wrap_cnt_branch_4b", {28'b0, cnt_branch_b}, 0);
    chk("wrap_cnt_branch_32b", cnt_branch, 16);
    chk("wrap_cnt_mis", cnt_mis, 0);

    // Clear in a flush cycle beats the increment.
    drive(1'b1, 1'b0, 1'b1, 32'h3000, 32'h3004, 32'h3800, 2'b01);
    tick(); idle();
    chk("clrf0_flush", {31'b0, flush}, 1);
    tick();
    chk("clrf0_cnt_mis", cnt_mis, 1);
    drive(1'b1, 1'b0, 1'b1, 32'h3000, 32'h3004, 32'h3800, 2'b01);
    tick(); idle();
    chk("clrf1_flush", {31'b0, flush}, 1);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    chk("clrf_cnt_mis", cnt_mis, 0);
    chk("clrf_cnt_mis_nobpu", {28'b0, cnt_mis_b}, 0);

    // Asynchronous reset during a flush.
    drive(1'b1, 1'b0, 1'b1, 32'h4000, 32'h4004, 32'h4800, 2'b01);
    tick(); idle();
    chk("rf_flush", {31'b0, flush}, 1);
    chk("rf_nxt_pc", nxt_pc, 32'h4800);
    rst_ni = 1'b0;
    #1;
    chk("rf_flush_drop", {31'b0, flush}, 0);
    chk("rf_nxt_pc_init", nxt_pc, 32'h200);
    chk("rf_update", {31'b0, update}, 0);
    chk("rf_cnt_branch", cnt_branch, 0);
    #2;
    rst_ni = 1'b1;
    tick();
    chk("rf_post_flush", {31'b0, flush}, 0);
    chk("rf_post_cnt_mis", cnt_mis, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
